subtractor_serial: RTL and testbench
====================================

// Module: subtractor_serial
// PURPOSE
//  Digit-serial subtractor; the inverse arithmetic companion of the datapath adder.
//  Accepts operands x, y and borrow-in over a valid/ready handshake.
//  Computes x - y - bin, DIGIT bits per cycle, LSB first.
//  Returns a registered SWIDTH-bit difference plus a zero flag over a second valid/ready handshake.
//  Sits beside the adder in the arithmetic unit; trades latency for area on wide operands.
// PARAMETERS
//  WIDTH   32         operand width; must be an integer multiple of DIGIT
//  DIGIT   8          bits processed per cycle (1..WIDTH)
//  SWIDTH  WIDTH+1    result width; MSB is the final borrow (1 => x < y+bin)
// PORTS
//  clk        in   1        single clock, rising edge
//  rst_n      in   1        asynchronous, active-low reset
//  clr        in   1        synchronous abort/clear, active high
//  in_valid   in   1        operands valid
//  in_ready   out  1        block can accept operands
//  bin        in   1        borrow in
//  x          in   WIDTH    minuend
//  y          in   WIDTH    subtrahend
//  out_valid  out  1        dif_r/zero_r valid
//  out_ready  in   1        consumer accepts result
//  dif_r      out  SWIDTH   {0,x} - {0,y} - bin, mod 2^SWIDTH
//  zero_r     out  1        dif_r == 0
// BEHAVIOUR
//  - Clock and reset: one clock (clk); reset rst_n is asynchronous, active-low.
//  - Reset values: state=IDLE, out_valid=0, dif_r=0, zero_r=0, digit counter=0.
//    in_ready=1 while rst_n is low and after release.
//  - States: IDLE, RUN and DONE.
//    IDLE: in_ready=1. in_valid&in_ready captures x, y, bin into shift regs -> RUN, cnt=0.
//    RUN: each cycle, one DIGIT slice is subtracted with the stored borrow.
//      The slice is shifted into the result reg; cnt++.
//      On the NDIG-th slice (NDIG=WIDTH/DIGIT) -> DONE.
//      Final borrow goes to dif_r[SWIDTH-1]; zero_r is registered at the same edge.
//    DONE: out_valid=1. out_ready=1 -> IDLE.
//  - Latency: accept at edge T -> out_valid seen after edge T+NDIG (DIGIT=WIDTH: 1 cycle).
//    Throughput: one op per NDIG+2 cycles. No overlap: in_ready=0 in RUN and DONE.
//  - in_valid while in_ready=0 is ignored (not latched).
//  - Backpressure: in DONE with out_ready=0, dif_r/zero_r/out_valid hold unchanged indefinitely.
//  - Clear: clr has priority over all handshakes in any state. Next edge: IDLE, out_valid=0.
//    dif_r and zero_r are cleared to 0. Any in-flight op is discarded.
//  - Reset mid-RUN/DONE: immediate (async) return to reset values. No partial result escapes.
//  - Arithmetic: borrow ripples across digit boundaries via a 1-bit registered borrow.
//    The result is bit-exact to the combinational SWIDTH-bit subtraction. No saturation.
//  - dif_r and zero_r change only at the DONE-entry edge or on clr/reset.
// STRUCTURE
//  - Shared package arith_pkg holds the state encoding (IDLE/RUN/DONE) and the NDIG computation.
//  - It also holds a width-check elaboration assertion (WIDTH % DIGIT == 0).
//  - Sub-module sub_digit: combinational DIGIT-bit ripple-borrow slice.
//    Inputs a, b, bi; outputs d, bo. Instantiated once and time-multiplexed by the FSM.
// TESTING (WIDTH=32, DIGIT=8, NDIG=4)
//  1. Reset: assert rst_n=0 mid-RUN -> out_valid=0, dif_r=0, zero_r=0 at once.
//     in_ready=1 after release; a fresh op completes normally.
//  2. Basic: x=10, y=3, bin=0 -> out_valid 4 edges after accept, dif_r=33'h0_0000_0007, zero_r=0.
//  3. Zero/borrow: x=5,y=5,bin=0 -> dif_r=0, zero_r=1.
//     x=0,y=1,bin=0 -> dif_r=33'h1_FFFF_FFFF, zero_r=0.
//  4. Cross-digit borrow: x=32'h0000_0100, y=1 -> dif_r=33'h0_0000_00FF.
//     x=32'hFFFF_FFFF, y=0, bin=1 -> 33'h0_FFFF_FFFE.
//  5. Backpressure: hold out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0.
//     in_valid pulses are ignored. The next op starts only after out_ready.
//  6. Clear: clr=1 in cycle 2 of RUN -> next edge IDLE, out_valid never asserts.
//     A random back-to-back stream (10k ops) then matches the reference model x-y-bin.

Source files
------------

// File: rtl/subtractor_serial_pkg.sv
// Shared definitions for the digit-serial subtractor: FSM encoding and
// parameter helpers used at elaboration time.
package subtractor_serial_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int ndig(input int width, input int digit);
        return width / digit;
    endfunction

    function automatic bit width_ok(input int width, input int digit);
        return (digit >= 1) && (digit <= width) && ((width % digit) == 0);
    endfunction

endpackage

// File: rtl/subtractor_serial_if.sv
// Operand and result handshakes of the digit-serial subtractor.
// The master side supplies operands and consumes results.
interface subtractor_serial_if #(
    parameter int WIDTH  = 32,
    parameter int SWIDTH = WIDTH + 1
);
    logic              in_valid;
    logic              in_ready;
    logic              bin;
    logic [WIDTH-1:0]  x;
    logic [WIDTH-1:0]  y;
    logic              out_valid;
    logic              out_ready;
    logic [SWIDTH-1:0] dif_r;
    logic              zero_r;

    modport master (
        output in_valid, bin, x, y, out_ready,
        input  in_ready, out_valid, dif_r, zero_r
    );

    modport slave (
        input  in_valid, bin, x, y, out_ready,
        output in_ready, out_valid, dif_r, zero_r
    );
endinterface

// File: rtl/subtractor_serial_sub_digit.sv
// One DIGIT-bit ripple-borrow slice: {bo, d} = a - b - bi.
module subtractor_serial_sub_digit #(
    parameter int DIGIT = 8
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             bi,
    output logic [DIGIT-1:0] d,
    output logic             bo
);
    logic [DIGIT:0] diff;

    // The extra top bit goes to 1 exactly when the slice result is negative.
    assign diff = {1'b0, a} - {1'b0, b} - {{DIGIT{1'b0}}, bi};
    assign d    = diff[DIGIT-1:0];
    assign bo   = diff[DIGIT];
endmodule

// File: rtl/subtractor_serial.sv
// Digit-serial subtractor: x - y - bin, DIGIT bits per cycle, LSB first,
// with a one-bit registered borrow carried between slices.
module subtractor_serial
    import subtractor_serial_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int DIGIT  = 8,
    parameter int SWIDTH = WIDTH + 1
) (
    input logic               clk,
    input logic               rst_n,
    input logic               clr,
    subtractor_serial_if.slave bus
);
    localparam int NDIG  = ndig(WIDTH, DIGIT);
    localparam int CNT_W = $clog2(NDIG) + 1;

    if (!width_ok(WIDTH, DIGIT) || (SWIDTH != WIDTH + 1)) begin : g_param_err
        $error("subtractor_serial: WIDTH must be a multiple of DIGIT and SWIDTH = WIDTH+1");
    end

    state_t                   state;
    state_t                   state_nxt;
    logic [CNT_W-1:0]         cnt;
    logic [WIDTH-1:0]         xs;
    logic [WIDTH-1:0]         ys;
    logic [WIDTH-1:0]         acc;
    logic [WIDTH-1:0]         acc_nxt;
    logic [WIDTH+DIGIT-1:0]   acc_cat;
    logic                     br;
    logic [DIGIT-1:0]         d;
    logic                     bo;
    logic                     accept;
    logic                     last;

    subtractor_serial_sub_digit #(.DIGIT(DIGIT)) u_digit (
        .a  (xs[DIGIT-1:0]),
        .b  (ys[DIGIT-1:0]),
        .bi (br),
        .d  (d),
        .bo (bo)
    );

    assign accept  = bus.in_valid && (state == IDLE) && !clr;
    assign last    = (state == RUN) && (cnt == CNT_W'(NDIG - 1));
    // New slice enters at the top; after NDIG shifts acc holds the full difference.
    assign acc_cat = {d, acc};
    assign acc_nxt = acc_cat[WIDTH+DIGIT-1:DIGIT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (clr) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (accept) state_nxt = RUN;
                RUN:     if (last) state_nxt = DONE;
                DONE:    if (bus.out_ready) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        bus.in_ready  = (state == IDLE);
        bus.out_valid = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            bus.dif_r  <= '0;
            bus.zero_r <= 1'b0;
        end else if (clr) begin
            cnt        <= '0;
            bus.dif_r  <= '0;
            bus.zero_r <= 1'b0;
        end else begin
            if (accept)             cnt <= '0;
            else if (state == RUN)  cnt <= cnt + CNT_W'(1);
            if (last) begin
                bus.dif_r  <= {bo, acc_nxt};
                bus.zero_r <= ({bo, acc_nxt} == '0);
            end
        end
    end

    // Operand/partial-result datapath needs no reset: it is loaded on accept.
    always_ff @(posedge clk) begin
        if (accept) begin
            xs <= bus.x;
            ys <= bus.y;
            br <= bus.bin;
        end else if (state == RUN) begin
            xs  <= xs >> DIGIT;
            ys  <= ys >> DIGIT;
            br  <= bo;
            acc <= acc_nxt;
        end
    end
endmodule

// File: tb/tb_subtractor_serial.sv
// Directed and random checks of subtractor_serial against a combinational
// x - y - bin reference, with results queued at accept and popped at output.
module tb_subtractor_serial;
    localparam int WIDTH  = 32;
    localparam int DIGIT  = 8;
    localparam int SWIDTH = WIDTH + 1;
    localparam int NDIG   = WIDTH / DIGIT;

    logic clk = 1'b0;
    logic rst_n;
    logic clr;
    int   vectors = 0;
    int   miscompares = 0;
    logic [SWIDTH:0] exp_q[$];

    subtractor_serial_if #(.WIDTH(WIDTH), .SWIDTH(SWIDTH)) bus ();

    subtractor_serial #(.WIDTH(WIDTH), .DIGIT(DIGIT), .SWIDTH(SWIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [SWIDTH:0] model(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b,
                                              input logic bi);
        logic [SWIDTH-1:0] r;
        r = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, bi};
        return {(r == '0), r};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic bi);
        int n;
        n = 0;
        bus.x = a;
        bus.y = b;
        bus.bin = bi;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 50) begin
            step();
            n++;
        end
        if (!bus.in_ready) chk("in_ready_timeout", 64'(bus.in_ready), 64'd1);
        step();
        bus.in_valid = 1'b0;
        exp_q.push_back(model(a, b, bi));
    endtask

    task automatic wait_out(input bit check_lat);
        int n;
        n = 0;
        while (!bus.out_valid && n < 20) begin
            step();
            n++;
        end
        if (check_lat) chk("latency", 64'(n), 64'(NDIG));
        else if (!bus.out_valid) chk("out_valid_timeout", 64'(bus.out_valid), 64'd1);
    endtask

    task automatic cmp_pop(input string tag);
        logic [SWIDTH:0] e;
        if (exp_q.size() == 0) begin
            chk({tag, "_queue_empty"}, 64'd0, 64'd1);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_dif"}, 64'(bus.dif_r), 64'(e[SWIDTH-1:0]));
            chk({tag, "_zero"}, 64'(bus.zero_r), 64'(e[SWIDTH]));
        end
    endtask

    task automatic release_out();
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
    endtask

    task automatic op(input string tag, input logic [WIDTH-1:0] a,
                      input logic [WIDTH-1:0] b, input logic bi, input bit check_lat);
        send(a, b, bi);
        wait_out(check_lat);
        cmp_pop(tag);
        release_out();
    endtask

    initial begin
        logic [SWIDTH-1:0] held_dif;
        logic              held_zero;
        int                seen;

        rst_n = 1'b0;
        clr = 1'b0;
        bus.in_valid = 1'b0;
        bus.bin = 1'b0;
        bus.x = '0;
        bus.y = '0;
        bus.out_ready = 1'b0;
        repeat (2) step();
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_dif", 64'(bus.dif_r), 64'd0);
        chk("rst_zero", 64'(bus.zero_r), 64'd0);
        rst_n = 1'b1;
        step();
        chk("post_rst_in_ready", 64'(bus.in_ready), 64'd1);

        op("basic", 32'd10, 32'd3, 1'b0, 1'b1);
        op("equal", 32'd5, 32'd5, 1'b0, 1'b1);
        op("underflow", 32'd0, 32'd1, 1'b0, 1'b1);
        op("xdigit", 32'h0000_0100, 32'd1, 1'b0, 1'b1);
        op("bin_max", 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b1);

        // Reset in the middle of RUN: outputs drop asynchronously.
        send(32'h1234_5678, 32'h0000_0001, 1'b0);
        step();
        rst_n = 1'b0;
        #1;
        chk("midrun_rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("midrun_rst_dif", 64'(bus.dif_r), 64'd0);
        chk("midrun_rst_zero", 64'(bus.zero_r), 64'd0);
        chk("midrun_rst_in_ready", 64'(bus.in_ready), 64'd1);
        exp_q.delete();
        step();
        rst_n = 1'b1;
        step();
        chk("after_rst_in_ready", 64'(bus.in_ready), 64'd1);
        op("after_rst", 32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 1'b1);

        // Backpressure: DONE holds while out_ready is low, new operands ignored.
        send(32'd100, 32'd58, 1'b1);
        wait_out(1'b1);
        held_dif = bus.dif_r;
        held_zero = bus.zero_r;
        cmp_pop("bp");
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = i[0];
            bus.x = 32'hDEAD_0000 + 32'(i);
            step();
            chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
            chk("bp_dif_hold", 64'(bus.dif_r), 64'(held_dif));
            chk("bp_zero_hold", 64'(bus.zero_r), 64'(held_zero));
            chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
        end
        bus.in_valid = 1'b0;
        release_out();
        chk("bp_released_out_valid", 64'(bus.out_valid), 64'd0);
        chk("bp_released_in_ready", 64'(bus.in_ready), 64'd1);
        step();
        chk("bp_no_stray_op", 64'(bus.in_ready), 64'd1);

        // Clear in the second RUN cycle discards the operation.
        send(32'h0F0F_0F0F, 32'h0101_0101, 1'b0);
        step();
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clr_in_ready", 64'(bus.in_ready), 64'd1);
        chk("clr_out_valid", 64'(bus.out_valid), 64'd0);
        chk("clr_dif", 64'(bus.dif_r), 64'd0);
        chk("clr_zero", 64'(bus.zero_r), 64'd0);
        exp_q.delete();
        seen = 0;
        repeat (NDIG + 2) begin
            step();
            if (bus.out_valid) seen++;
        end
        chk("clr_no_output", 64'(seen), 64'd0);

        for (int i = 0; i < 10000; i++) begin
            logic [WIDTH-1:0] a;
            logic [WIDTH-1:0] b;
            a = $urandom();
            b = $urandom();
            case ($urandom_range(0, 7))
                0: b = a;
                1: a = '0;
                2: b = '1;
                3: a = {a[WIDTH-1:DIGIT], {DIGIT{1'b0}}};
                default: ;
            endcase
            op("rand", a, b, 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
